// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet framer.
// FSM state encoding and the default header sync word.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR_SYNC,
        HDR_SEQ,
        PAYLOAD
    } state_t;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA5A5;

endpackage

// File: rtl/axis_pkt_framer.sv
// AXI-Stream packet framer: prepends a sync word and a sequence
// number to each packet of pkt_len samples, tlast on the final sample.
module axis_pkt_framer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 12,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD =
        DATA_WIDTH'(SYNC_WORD_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [15:0]           pkt_count
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [15:0]           seq_q, seq_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  slot_free;

    assign slot_free     = !valid_q || m_axis_tready;
    assign s_axis_tready = (state_q == PAYLOAD) && slot_free;
    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign pkt_count     = cnt_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        beat_d  = beat_q;
        len_d   = len_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;

        // A packet counts as sent once its tlast beat leaves.
        if (valid_q && m_axis_tready) begin
            valid_d = 1'b0;
            if (last_q) begin
                seq_d = seq_q + 16'd1;
                cnt_d = cnt_q + 16'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    len_d   = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                    state_d = HDR_SYNC;
                end
            end
            HDR_SYNC: begin
                if (slot_free) begin
                    data_d  = SYNC_WORD;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = HDR_SEQ;
                end
            end
            HDR_SEQ: begin
                if (slot_free) begin
                    data_d  = DATA_WIDTH'(seq_q);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (s_axis_tvalid && slot_free) begin
                    data_d  = s_axis_tdata;
                    valid_d = 1'b1;
                    if (beat_q == len_q - LEN_WIDTH'(1)) begin
                        last_d  = 1'b1;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        last_d = 1'b0;
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            len_q   <= LEN_WIDTH'(1);
            seq_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Self-checking bench for axis_pkt_framer: directed table,
// hand-written corner sequences and randomized packets vs a model.
module tb_axis_pkt_framer;

    localparam int DW = 16;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [15:0]   pkt_count;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        int len;
        int src_rate;
        int snk_rate;
        bit toggle;
        bit full_rate;
        int exp_beats;
    } vec_t;

    beat_t       cap_q[$];
    logic [15:0] src_q[$];
    int          src_rate = 100;
    int          snk_rate = 100;
    bit          toggle = 1'b0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_acc = 0;
    int          n_srdy = 0;
    logic [15:0] exp_seq = '0;
    logic [15:0] exp_cnt = '0;
    bit          hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic        hold_l = 1'b0;

    axis_pkt_framer #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .SYNC_WORD (16'hA5A5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pkt_len      (pkt_len),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: drive at posedge+1, observe at negedge.
    task automatic cycle();
        s_tvalid = 1'b0;
        s_tdata  = 16'($urandom);
        if (src_q.size() > 0 && $urandom_range(99) < src_rate) begin
            s_tvalid = 1'b1;
            s_tdata  = src_q[0];
        end
        if (toggle) m_tready = ~m_tready;
        else m_tready = ($urandom_range(99) < snk_rate);
        @(negedge clk);
        cyc++;
        if (s_tready) n_srdy++;
        if (s_tvalid && s_tready) begin
            void'(src_q.pop_front());
            n_acc++;
        end
        if (hold_v) begin
            chk("hold_valid", 32'(m_tvalid), 1);
            chk("hold_data", 32'(m_tdata), 32'(hold_d));
            chk("hold_last", 32'(m_tlast), 32'(hold_l));
        end
        hold_v = m_tvalid && !m_tready;
        hold_d = m_tdata;
        hold_l = m_tlast;
        if (m_tvalid && m_tready)
            cap_q.push_back('{m_tdata, m_tlast, cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        hold_v  = 1'b0;
        src_q.delete();
        cap_q.delete();
        exp_seq = '0;
        exp_cnt = '0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    task automatic run_until(input int n, input int budget,
                             input string name);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk({name, "_timeout"}, 32'(cap_q.size() >= n), 1);
    endtask

    // Reference: sync, sequence number, then the samples; tlast on the last.
    task automatic check_pkt(input string name, input int len,
                             input logic [15:0] smp[$]);
        beat_t exp_q[$];
        int    eff = (len == 0) ? 1 : len;
        exp_q.push_back('{16'hA5A5, 1'b0, 0});
        exp_q.push_back('{exp_seq, 1'b0, 0});
        for (int i = 0; i < eff; i++)
            exp_q.push_back('{smp[i], i == eff - 1, 0});
        chk({name, "_beats"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i),
                32'(cap_q[i].data), 32'(exp_q[i].data));
            chk($sformatf("%s_last%0d", name, i),
                32'(cap_q[i].last), 32'(exp_q[i].last));
        end
        exp_seq++;
        exp_cnt++;
        chk({name, "_pkt_count"}, 32'(pkt_count), 32'(exp_cnt));
    endtask

    task automatic send_pkt(input string name, input int len,
                            input bit rnd);
        logic [15:0] smp[$];
        int          eff = (len == 0) ? 1 : len;
        for (int i = 0; i < eff; i++)
            smp.push_back(rnd ? 16'($urandom) : 16'(i + 1));
        cap_q.delete();
        n_acc   = 0;
        src_q   = smp;
        pkt_len = LW'(len);
        enable  = 1'b1;
        cycle();
        enable  = 1'b0;
        pkt_len = LW'($urandom);
        run_until(eff + 2, 3000, name);
        check_pkt(name, len, smp);
        chk({name, "_accepted"}, 32'(n_acc), 32'(eff));
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{4, 100, 100, 1'b0, 1'b1, 6};
        vecs[1] = '{4, 100, 100, 1'b1, 1'b0, 6};
        vecs[2] = '{0, 100, 100, 1'b0, 1'b1, 3};
        vecs[3] = '{1, 50, 50, 1'b0, 1'b0, 3};
        vecs[4] = '{9, 70, 60, 1'b0, 1'b0, 11};

        @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        do_reset();

        for (int v = 0; v < 5; v++) begin
            src_rate = vecs[v].src_rate;
            snk_rate = vecs[v].snk_rate;
            toggle   = vecs[v].toggle;
            m_tready = 1'b0;
            send_pkt($sformatf("vec%0d", v), vecs[v].len, 1'b0);
            chk($sformatf("vec%0d_nbeats", v),
                32'(cap_q.size()), 32'(vecs[v].exp_beats));
            if (vecs[v].full_rate && cap_q.size() == vecs[v].exp_beats)
                chk($sformatf("vec%0d_rate", v),
                    32'(cap_q[vecs[v].exp_beats-1].cyc - cap_q[0].cyc),
                    32'(vecs[v].exp_beats - 1));
        end
        toggle   = 1'b0;
        src_rate = 100;
        snk_rate = 100;

        // Three back-to-back packets of two samples, enable held.
        do_reset();
        for (int i = 0; i < 6; i++) src_q.push_back(16'(16'h10 + i));
        pkt_len = LW'(2);
        enable  = 1'b1;
        begin
            int k = 0;
            while (cap_q.size() < 12 && k < 200) begin
                if (cap_q.size() >= 9) enable = 1'b0;
                cycle();
                k++;
            end
        end
        enable = 1'b0;
        chk("b2b_timeout", 32'(cap_q.size() >= 12), 1);
        if (cap_q.size() >= 12) begin
            chk("b2b_seq0", 32'(cap_q[1].data), 0);
            chk("b2b_seq1", 32'(cap_q[5].data), 1);
            chk("b2b_seq2", 32'(cap_q[9].data), 2);
            chk("b2b_gap01", 32'(cap_q[4].cyc - cap_q[0].cyc), 5);
            chk("b2b_gap12", 32'(cap_q[8].cyc - cap_q[4].cyc), 5);
            chk("b2b_idle", 32'(cap_q[4].cyc - cap_q[3].cyc), 2);
            chk("b2b_last", 32'(cap_q[11].last), 1);
            chk("b2b_data", 32'(cap_q[10].data), 32'h14);
        end
        chk("b2b_pkt_count", 32'(pkt_count), 3);
        exp_seq = 16'd3;
        exp_cnt = 16'd3;

        // Reset two payload beats into an 8-sample packet.
        cap_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(16'(16'h80 + i));
        pkt_len = LW'(8);
        enable  = 1'b1;
        cycle();
        enable  = 1'b0;
        run_until(4, 100, "mid_rst");
        reset = 1'b1;
        #1;
        chk("mid_rst_tvalid", 32'(m_tvalid), 0);
        chk("mid_rst_tlast", 32'(m_tlast), 0);
        chk("mid_rst_tdata", 32'(m_tdata), 0);
        chk("mid_rst_s_tready", 32'(s_tready), 0);
        chk("mid_rst_pkt_count", 32'(pkt_count), 0);
        do_reset();
        send_pkt("after_rst", 1, 1'b1);

        // Latch 5, then drop enable and change pkt_len mid-packet.
        send_pkt("en_drop", 5, 1'b1);
        n_acc  = 0;
        n_srdy = 0;
        for (int i = 0; i < 3; i++) src_q.push_back(16'($urandom));
        repeat (20) cycle();
        chk("en_drop_idle_beats", 32'(cap_q.size()), 7);
        chk("en_drop_idle_tready", 32'(n_srdy), 0);
        chk("en_drop_idle_acc", 32'(n_acc), 0);
        src_q.delete();

        // Randomized packets, lengths and handshake rates.
        for (int p = 0; p < 30; p++) begin
            src_rate = int'($urandom_range(100, 30));
            snk_rate = int'($urandom_range(100, 30));
            send_pkt($sformatf("rnd%0d", p),
                     int'($urandom_range(12, 0)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
